pipe_alu: RTL
=============

PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  upstream presents an operation.
REQ-005 SHALL have port in_ready  output  1  block can accept an operation this cycle.
REQ-006 SHALL have port op  input  3  opcode (REQ-012).
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port out_valid  output  1  result registers hold an unconsumed result.
REQ-010 SHALL have port out_ready  input  1  downstream consumes the result this cycle.
REQ-011 SHALL have ports result (output, WIDTH, operation result), cout (output, 1, carry/borrow/overflow flag), zero (output, 1, high when result is all zeros) and acc (output, WIDTH, current accumulator value).

Function
REQ-012 SHALL decode op: 000 ADD a+b; 001 SUB a-b; 010 AND; 011 XOR; 100 OR; 101 ACC acc+a; 110 CLR (result 0, acc cleared); 111 RD (result = acc, acc unchanged).
REQ-013 SHALL accept an operation on a rising edge where in_valid and in_ready are both high; no other cycle changes result, cout, zero or acc.
REQ-014 SHALL drive in_ready = !out_valid | out_ready (combinational; one-entry output register, full throughput).
REQ-015 SHALL present the result of an accepted operation on result/cout/zero with out_valid high exactly 1 cycle after acceptance.
REQ-016 SHALL clear out_valid on an edge where out_valid and out_ready are high and no new operation is accepted; simultaneous consume and accept SHALL keep out_valid high and load the new result.
REQ-017 SHALL hold result, cout, zero and out_valid stable while out_valid is high and out_ready is low.
REQ-018 SHALL compute ADD/ACC at WIDTH+1 bits; cout = bit WIDTH (carry out); result = low WIDTH bits (wrap-around).
REQ-019 SHALL set cout for SUB to 1 when a < b (unsigned borrow); result = (a - b) mod 2^WIDTH.
REQ-020 SHALL set cout = 0 for AND, XOR, OR, CLR and RD.
REQ-021 SHALL, for ACC, write the (possibly saturated) result into acc on acceptance; for CLR, write 0 into acc; other ops leave acc unchanged.
REQ-022 SHALL compute zero from the registered result only.

Reset
REQ-023 SHALL, on a rising edge with rst_n low, set out_valid=0, result=0, cout=0, zero=1, acc=0, overriding any simultaneous accept or consume.
REQ-024 SHALL drop an operation in flight when reset is asserted mid-operation; the first accept after rst_n returns high behaves as from power-up.
REQ-025 SHALL drive in_ready=1 during and after reset while out_valid=0.

Configuration
REQ-026 SHALL, with macro PIPE_ALU_SAT_EN defined, saturate ADD and ACC to all-ones on carry and SUB to 0 on borrow; cout still reports the carry/borrow.
REQ-027 SHALL, without PIPE_ALU_SAT_EN, use wrap-around arithmetic per REQ-018/REQ-019; no other behaviour differs.

Verification (WIDTH=8)
REQ-028 SHALL cover ADD a=0xF0 b=0x20, out_ready=1 -> next cycle result=0x10 cout=1 zero=0 (SAT_EN: result=0xFF cout=1).
REQ-029 SHALL cover SUB a=0x05 b=0x05 -> result=0x00 zero=1 cout=0; SUB a=0x03 b=0x05 -> result=0xFE cout=1 (SAT_EN: 0x00, cout=1).
REQ-030 SHALL cover CLR, then ACC a=0x80 three times, then RD -> acc sequence 0x80, 0x00 (cout=1), 0x80; RD result=0x80 (SAT_EN: 0x80, 0xFF, 0xFF).
REQ-031 SHALL cover backpressure: out_ready=0 with in_valid=1 for 4 cycles -> one accept, in_ready=0 thereafter, result stable; out_ready=1 -> consume and next accept on the same edge.
REQ-032 SHALL cover rst_n low for 1 cycle while out_valid=1 and acc=0x55 -> out_valid=0, result=0, zero=1, acc=0, in_ready=1.
REQ-033 SHALL cover back-to-back XOR a=0xAA b=0xFF then OR a=0x0F b=0xF0 with out_ready=1 -> results 0x55 then 0xFF on consecutive cycles, out_valid continuously high.

Source files
------------

// File: rtl/pipe_alu.sv
// Single-stage ALU with a one-entry valid/ready output register and an accumulator.
// Optional build macro PIPE_ALU_SAT_EN: saturating ADD/ACC/SUB instead of wrap-around.
module pipe_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic [WIDTH-1:0] acc
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_ACC = 3'b101;
    localparam logic [2:0] OP_CLR = 3'b110;
    localparam logic [2:0] OP_RD  = 3'b111;

    // Carry-out in bit WIDTH selects saturation to all-ones when enabled.
    function automatic logic [WIDTH-1:0] sat_carry(input logic [WIDTH:0] s);
`ifdef PIPE_ALU_SAT_EN
        return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
`else
        return s[WIDTH-1:0];
`endif
    endfunction

    // Borrow in bit WIDTH selects clamping to zero when enabled.
    function automatic logic [WIDTH-1:0] sat_borrow(input logic [WIDTH:0] d);
`ifdef PIPE_ALU_SAT_EN
        return d[WIDTH] ? {WIDTH{1'b0}} : d[WIDTH-1:0];
`else
        return d[WIDTH-1:0];
`endif
    endfunction

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             accept;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   acc_s;
    logic [WIDTH:0]   sub_s;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign add_s = {1'b0, a} + {1'b0, b};
    assign acc_s = {1'b0, acc_q} + {1'b0, a};
    assign sub_s = {1'b0, a} - {1'b0, b};

    always_comb begin
        result_d = '0;
        cout_d   = 1'b0;
        acc_d    = acc_q;
        case (op)
            OP_ADD: begin
                result_d = sat_carry(add_s);
                cout_d   = add_s[WIDTH];
            end
            OP_SUB: begin
                result_d = sat_borrow(sub_s);
                cout_d   = sub_s[WIDTH];
            end
            OP_AND: result_d = a & b;
            OP_XOR: result_d = a ^ b;
            OP_OR:  result_d = a | b;
            OP_ACC: begin
                result_d = sat_carry(acc_s);
                cout_d   = acc_s[WIDTH];
                acc_d    = sat_carry(acc_s);
            end
            OP_CLR: begin
                result_d = '0;
                acc_d    = '0;
            end
            OP_RD:  result_d = acc_q;
            default: result_d = '0;
        endcase
    end

    // Output register stage: loads on accept, drains on consume-only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            acc_q       <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            result_q    <= result_d;
            cout_q      <= cout_d;
            acc_q       <= acc_d;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign zero      = (result_q == '0);
    assign acc       = acc_q;

endmodule
